// File: rtl/fifo2axi_sram_v1.sv
// fifo2axi_sram_v1: rebuilds 256-bit AXI4-Stream packets from the packed 192-bit SRAM payload words.
module fifo2axi_sram_v1 #(
  parameter int TDATA_WIDTH = 32,
  parameter int TUSER_WIDTH = 16,
  parameter int CROPPED_DATA_WIDTH = 24,
  parameter int WORD_WIDTH = 8*CROPPED_DATA_WIDTH+10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WORD_WIDTH-1:0]    din,
  input  logic                     din_valid,
  output logic                     din_ready,
  output logic [8*TDATA_WIDTH-1:0] m_tdata,
  output logic [TDATA_WIDTH-1:0]   m_tstrb,
  output logic [8*TUSER_WIDTH-1:0] m_tuser,
  output logic                     m_tlast,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic                     err,
  output logic [31:0]              pkt_count
);
  localparam int DW = 8*TDATA_WIDTH;
  localparam int PW = 8*CROPPED_DATA_WIDTH;
  localparam int UW = 8*TUSER_WIDTH;
  typedef enum logic [1:0] {HDR, BODY, FLUSH, DROP} state_t;
  state_t state, state_nx;
  logic [2:0] exp_ph, exp_nx, ph;
  logic [4:0] cnt;
  logic [PW-1:0] pay;
  logic [DW-1:0] acc, acc_nx, fl_data, fl_data_nx, full, nxt, mask, ld_data;
  logic [TDATA_WIDTH-1:0] fl_strb, fl_strb_nx, strb_n, ld_strb;
  logic [UW-1:0] tuser_q, tuser_nx;
  logic eop, free, take, split, ld, ld_last, err_set, unused_bit;
  assign pay = din[PW+9:10];
  assign cnt = din[9:5];
  assign ph = din[4:2];
  assign eop = din[1];
  assign unused_bit = din[0];
  // full: the beat completed by this word; nxt: what this word leaves for the following beat
  assign full = (ph == 3'd1) ? {{(DW-PW){1'b0}}, pay} :
                (ph == 3'd2) ? {pay[63:0], acc[191:0]} :
                (ph == 3'd3) ? {pay[127:0], acc[127:0]} : {pay, acc[63:0]};
  assign nxt = (ph == 3'd1) ? {{(DW-PW){1'b0}}, pay} :
               (ph == 3'd2) ? {128'b0, pay[191:64]} : {192'b0, pay[191:128]};
  assign strb_n = (cnt == 5'd0) ? '1 : (TDATA_WIDTH'(1) << cnt) - TDATA_WIDTH'(1);
  assign split = eop && cnt != 5'd0 && ((ph == 3'd2 && cnt <= 5'd24) || (ph == 3'd3 && cnt <= 5'd16));
  always_comb begin
    mask = '0;
    for (int i = 0; i < TDATA_WIDTH; i++) mask[8*i +: 8] = {8{strb_n[i]}};
  end
  always_comb begin
    free = !m_tvalid || m_tready;
    din_ready = (state == DROP) || ((state == HDR || state == BODY) && free);
    take = din_valid && din_ready;
    state_nx = state;
    exp_nx = exp_ph;
    acc_nx = acc;
    fl_data_nx = fl_data;
    fl_strb_nx = fl_strb;
    tuser_nx = tuser_q;
    ld = 1'b0;
    ld_last = 1'b0;
    ld_data = full;
    ld_strb = '1;
    err_set = 1'b0;
    if (state == FLUSH) begin
      if (free) begin
        ld = 1'b1;
        ld_last = 1'b1;
        ld_data = fl_data;
        ld_strb = fl_strb;
        state_nx = HDR;
      end
    end else if (take) begin
      if (state == DROP) begin
        if (eop) state_nx = HDR;
      end else if (state == HDR && ph == 3'd0) begin
        tuser_nx = pay[UW-1:0];
        exp_nx = 3'd1;
        state_nx = BODY;
      end else if (state == HDR || ph != exp_ph) begin
        err_set = 1'b1;
        state_nx = eop ? HDR : DROP;
      end else begin
        acc_nx = nxt;
        exp_nx = (ph == 3'd4) ? 3'd1 : ph + 3'd1;
        if (!eop) begin
          ld = ph != 3'd1;
        end else if (split) begin
          ld = 1'b1;
          fl_data_nx = nxt & mask;
          fl_strb_nx = strb_n;
          state_nx = FLUSH;
        end else begin
          ld = 1'b1;
          ld_last = 1'b1;
          ld_data = full & mask;
          ld_strb = strb_n;
          state_nx = HDR;
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) state <= HDR;
    else state <= state_nx;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      exp_ph <= 3'd1;
      acc <= '0;
      fl_data <= '0;
      fl_strb <= '0;
      tuser_q <= '0;
      m_tvalid <= 1'b0;
      m_tdata <= '0;
      m_tstrb <= '0;
      m_tuser <= '0;
      m_tlast <= 1'b0;
      err <= 1'b0;
      pkt_count <= '0;
    end else begin
      exp_ph <= exp_nx;
      acc <= acc_nx;
      fl_data <= fl_data_nx;
      fl_strb <= fl_strb_nx;
      tuser_q <= tuser_nx;
      if (ld) begin
        m_tvalid <= 1'b1;
        m_tdata <= ld_data;
        m_tstrb <= ld_strb;
        m_tuser <= tuser_q;
        m_tlast <= ld_last;
      end else if (m_tready) begin
        m_tvalid <= 1'b0;
      end
      if (err_set) err <= 1'b1;
      if (m_tvalid && m_tready && m_tlast) pkt_count <= pkt_count + 32'd1;
    end
  end
endmodule

// File: tb/tb_fifo2axi_sram_v1.sv
// tb_fifo2axi_sram_v1: directed checks of packet reassembly, flush, backpressure, framing errors and reset.
module tb_fifo2axi_sram_v1;
  logic clk = 1'b0, reset = 1'b1;
  logic [201:0] din = '0;
  logic din_valid = 1'b0, din_ready;
  logic [255:0] m_tdata;
  logic [31:0] m_tstrb, pkt_count;
  logic [127:0] m_tuser;
  logic m_tlast, m_tvalid, err;
  logic m_tready = 1'b1;
  bit toggle = 1'b0;
  int vectors = 0, errors = 0, exp_pkts = 0;
  typedef struct packed {logic [255:0] d; logic [31:0] s; logic [127:0] u; logic l;} beat_t;
  beat_t q[$];
  logic [1023:0] stream, s1;

  fifo2axi_sram_v1 dut (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .m_tdata(m_tdata), .m_tstrb(m_tstrb), .m_tuser(m_tuser), .m_tlast(m_tlast),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .err(err), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  // collect every accepted beat just before the rising edge
  always @(negedge clk) begin
    if (toggle) m_tready = ~m_tready;
    #4;
    if (!reset && m_tvalid && m_tready) q.push_back({m_tdata, m_tstrb, m_tuser, m_tlast});
  end

  // reference: the packet is a contiguous byte stream, beat j = bytes 32j..32j+31
  function automatic logic [31:0] strb_of(input int nbytes, input int j);
    int nb, r;
    nb = (nbytes + 31) / 32;
    r = nbytes - 32*j;
    return (j < nb-1 || r == 32) ? 32'hFFFF_FFFF : (32'd1 << r) - 32'd1;
  endfunction

  function automatic logic [255:0] data_of(input logic [1023:0] s, input int nbytes, input int j);
    logic [31:0] st;
    logic [255:0] d;
    st = strb_of(nbytes, j);
    d = s[256*j +: 256];
    for (int i = 0; i < 32; i++) if (!st[i]) d[8*i +: 8] = 8'h00;
    return d;
  endfunction

  task automatic fill(input int seed);
    for (int i = 0; i < 128; i++) stream[8*i +: 8] = 8'(i*13 + seed);
  endtask

  task automatic send(input logic [191:0] pay, input logic [4:0] cnt, input logic [2:0] ph, input logic eop);
    bit ok;
    ok = 1'b0;
    din = {pay, cnt, ph, eop, 1'b0};
    din_valid = 1'b1;
    for (int t = 0; t < 60 && !ok; t++) begin
      #4;
      ok = din_ready;
      @(negedge clk);
    end
    din_valid = 1'b0;
    if (!ok) begin
      vectors++;
      errors++;
      $display("FAIL send_timeout ph=%0d got din_ready=0 want 1", ph);
    end
  endtask

  task automatic send_pkt(input int nbytes, input logic [127:0] tu);
    int nw;
    nw = (nbytes + 23) / 24;
    send({64'hA5A5_5A5A_0F0F_F0F0, tu}, 5'd0, 3'd0, 1'b0);
    for (int k = 0; k < nw; k++)
      send(stream[192*k +: 192], (k == nw-1) ? 5'(nbytes % 32) : 5'd0, 3'(k % 4 + 1), 1'(k == nw-1));
  endtask

  task automatic drain(input int n);
    for (int t = 0; t < 200 && q.size() < n; t++) @(negedge clk);
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({m_tvalid, m_tlast, err, pkt_count, m_tdata, m_tstrb, m_tuser} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got tvalid=%b tlast=%b err=%b cnt=%0d want all 0", m_tvalid, m_tlast, err, pkt_count);
    end
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (din_ready !== 1'b1) begin errors++; $display("FAIL reset_din_ready got %b want 1", din_ready); end
  endtask

  task automatic test_packets;
    int sizes[9] = '{24, 40, 48, 56, 60, 64, 72, 96, 120};
    for (int p = 0; p < 9; p++) begin
      int n;
      int nb;
      logic [127:0] tu;
      n = sizes[p];
      nb = (n + 31) / 32;
      tu = {32'(p), 88'h0, 8'hAB};
      fill(p*17 + 3);
      q.delete();
      send_pkt(n, tu);
      drain(nb);
      exp_pkts++;
      vectors++;
      if (q.size() != nb) begin errors++; $display("FAIL pkt%0d_beat_count got %0d want %0d", n, q.size(), nb); end
      for (int j = 0; j < nb && j < q.size(); j++) begin
        beat_t e;
        e = {data_of(stream, n, j), strb_of(n, j), tu, 1'(j == nb-1)};
        vectors++;
        if (q[j] !== e) begin
          errors++;
          $display("FAIL pkt%0d_beat%0d got %h %h %h %b want %h %h %h %b", n, j, q[j].d, q[j].s, q[j].u, q[j].l, e.d, e.s, e.u, e.l);
        end
      end
      vectors++;
      if (pkt_count !== 32'(exp_pkts)) begin errors++; $display("FAIL pkt%0d_count got %0d want %0d", n, pkt_count, exp_pkts); end
    end
  endtask

  task automatic test_flush;
    logic [127:0] tu;
    tu = {120'h0, 8'h40};
    fill(77);
    q.delete();
    send({64'h0, tu}, 5'd0, 3'd0, 1'b0);
    send(stream[191:0], 5'd0, 3'd1, 1'b0);
    send(stream[383:192], 5'd8, 3'd2, 1'b1);
    vectors++;
    if ({din_ready, m_tvalid, m_tlast} !== 3'b010) begin errors++; $display("FAIL flush_hold got ready/valid/last=%b%b%b want 010", din_ready, m_tvalid, m_tlast); end
    @(negedge clk);
    vectors++;
    if ({din_ready, m_tvalid, m_tlast} !== 3'b111) begin errors++; $display("FAIL flush_release got ready/valid/last=%b%b%b want 111", din_ready, m_tvalid, m_tlast); end
    drain(2);
    exp_pkts++;
    vectors++;
    if (q.size() != 2) begin errors++; $display("FAIL flush_beat_count got %0d want 2", q.size()); end
    for (int j = 0; j < 2 && j < q.size(); j++) begin
      beat_t e;
      e = {data_of(stream, 40, j), strb_of(40, j), tu, 1'(j == 1)};
      vectors++;
      if (q[j] !== e) begin
        errors++;
        $display("FAIL flush_beat%0d got %h %h %h %b want %h %h %h %b", j, q[j].d, q[j].s, q[j].u, q[j].l, e.d, e.s, e.u, e.l);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [127:0] tu;
    tu = 128'h1234_5678_9ABC_DEF0_0F1E_2D3C_4B5A_6978;
    fill(150);
    q.delete();
    toggle = 1'b1;
    send_pkt(96, tu);
    drain(3);
    toggle = 1'b0;
    m_tready = 1'b1;
    @(negedge clk);
    exp_pkts++;
    vectors++;
    if (q.size() != 3) begin errors++; $display("FAIL bp_beat_count got %0d want 3", q.size()); end
    for (int j = 0; j < 3 && j < q.size(); j++) begin
      beat_t e;
      e = {data_of(stream, 96, j), strb_of(96, j), tu, 1'(j == 2)};
      vectors++;
      if (q[j] !== e) begin
        errors++;
        $display("FAIL bp_beat%0d got %h %h %h %b want %h %h %h %b", j, q[j].d, q[j].s, q[j].u, q[j].l, e.d, e.s, e.u, e.l);
      end
    end
    vectors++;
    if (pkt_count !== 32'(exp_pkts)) begin errors++; $display("FAIL bp_count got %0d want %0d", pkt_count, exp_pkts); end
  endtask

  task automatic test_back_to_back;
    logic [127:0] tua, tub;
    tua = {64'h0, 64'hAAAA_0000_1111_00AB};
    tub = {64'h0, 64'hBBBB_0000_2222_00CD};
    q.delete();
    fill(200);
    s1 = stream;
    send_pkt(64, tua);
    fill(90);
    send_pkt(60, tub);
    drain(4);
    exp_pkts += 2;
    vectors++;
    if (q.size() != 4) begin errors++; $display("FAIL b2b_beat_count got %0d want 4", q.size()); end
    for (int j = 0; j < 4 && j < q.size(); j++) begin
      beat_t e;
      e = (j < 2) ? {data_of(s1, 64, j), strb_of(64, j), tua, 1'(j == 1)}
                  : {data_of(stream, 60, j-2), strb_of(60, j-2), tub, 1'(j == 3)};
      vectors++;
      if (q[j] !== e) begin
        errors++;
        $display("FAIL b2b_beat%0d got %h %h %h %b want %h %h %h %b", j, q[j].d, q[j].s, q[j].u, q[j].l, e.d, e.s, e.u, e.l);
      end
    end
    vectors++;
    if (pkt_count !== 32'(exp_pkts)) begin errors++; $display("FAIL b2b_count got %0d want %0d", pkt_count, exp_pkts); end
  endtask

  task automatic test_phase_error;
    logic [127:0] tu;
    tu = {120'h0, 8'hAB};
    fill(33);
    q.delete();
    send({64'h0, 128'hDEAD}, 5'd0, 3'd0, 1'b0);
    send(stream[191:0], 5'd0, 3'd1, 1'b0);
    send(stream[383:192], 5'd0, 3'd3, 1'b0);
    vectors++;
    if (err !== 1'b1) begin errors++; $display("FAIL perr_err_set got %b want 1", err); end
    send(stream[575:384], 5'd0, 3'd2, 1'b0);
    send(stream[767:576], 5'd0, 3'd4, 1'b1);
    drain(0);
    vectors++;
    if (q.size() != 0) begin errors++; $display("FAIL perr_dropped_beats got %0d want 0", q.size()); end
    fill(44);
    send_pkt(64, tu);
    drain(2);
    exp_pkts++;
    vectors++;
    if (q.size() != 2) begin errors++; $display("FAIL perr_next_beat_count got %0d want 2", q.size()); end
    for (int j = 0; j < 2 && j < q.size(); j++) begin
      beat_t e;
      e = {data_of(stream, 64, j), strb_of(64, j), tu, 1'(j == 1)};
      vectors++;
      if (q[j] !== e) begin
        errors++;
        $display("FAIL perr_beat%0d got %h %h %h %b want %h %h %h %b", j, q[j].d, q[j].s, q[j].u, q[j].l, e.d, e.s, e.u, e.l);
      end
    end
    vectors++;
    if (err !== 1'b1 || pkt_count !== 32'(exp_pkts)) begin
      errors++;
      $display("FAIL perr_sticky got err=%b cnt=%0d want err=1 cnt=%0d", err, pkt_count, exp_pkts);
    end
  endtask

  task automatic test_reset_mid;
    logic [127:0] tu;
    tu = {120'h0, 8'hAB};
    m_tready = 1'b0;
    fill(61);
    q.delete();
    send({64'h0, 128'h77}, 5'd0, 3'd0, 1'b0);
    send(stream[191:0], 5'd0, 3'd1, 1'b0);
    send(stream[383:192], 5'd0, 3'd2, 1'b0);
    vectors++;
    if (m_tvalid !== 1'b1) begin errors++; $display("FAIL rmid_pending got tvalid=%b want 1", m_tvalid); end
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if ({m_tvalid, err, pkt_count} !== '0) begin
      errors++;
      $display("FAIL rmid_cleared got tvalid=%b err=%b cnt=%0d want 0 0 0", m_tvalid, err, pkt_count);
    end
    reset = 1'b0;
    m_tready = 1'b1;
    exp_pkts = 1;
    fill(12);
    send_pkt(64, tu);
    drain(2);
    vectors++;
    if (q.size() != 2) begin errors++; $display("FAIL rmid_beat_count got %0d want 2", q.size()); end
    for (int j = 0; j < 2 && j < q.size(); j++) begin
      beat_t e;
      e = {data_of(stream, 64, j), strb_of(64, j), tu, 1'(j == 1)};
      vectors++;
      if (q[j] !== e) begin
        errors++;
        $display("FAIL rmid_beat%0d got %h %h %h %b want %h %h %h %b", j, q[j].d, q[j].s, q[j].u, q[j].l, e.d, e.s, e.u, e.l);
      end
    end
    vectors++;
    if (pkt_count !== 32'(exp_pkts)) begin errors++; $display("FAIL rmid_count got %0d want %0d", pkt_count, exp_pkts); end
  endtask

  initial begin
    test_reset;
    test_packets;
    test_flush;
    test_backpressure;
    test_back_to_back;
    test_phase_error;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
